// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard controller and the stage registers.
package pipeline_hazard_ctrl_pkg;

    // Width of an architectural register index (R0..R15, with R15 being the PC).
    localparam int REG_IDX_W = 4;

    // Sequencer states: normal flow, waiting on data memory, and sticky timeout.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_e;

    // Control bundle sent to the PC and pipeline registers.
    // Field order matches the bit order used when the bundle is viewed as a vector.
    typedef struct packed {
        logic freezePc;
        logic freezeIfReg;
        logic flushIfReg;
        logic bubbleId;
        logic freezeBack;
    } hazard_ctrl_t;

    // Bundle value meaning "let every stage advance normally".
    localparam hazard_ctrl_t CTRL_IDLE = '0;

    // True when a source register is actually read and names the given destination.
    // R15 gets no special treatment; it is compared like any other index.
    function automatic logic srcMatch(
        input logic [REG_IDX_W-1:0] src,
        input logic                 live,
        input logic [REG_IDX_W-1:0] dest
    );
        return live && (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational data-hazard detector for the instruction sitting in ID.
// Without forwarding any pending write in EX or MEM to a live source stalls;
// with forwarding only a load still in EX (load-use) stalls.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b0
)
(
    input  logic [REG_IDX_W-1:0] id_src1_i,
    input  logic [REG_IDX_W-1:0] id_src2_i,
    input  logic                 id_use_src1_i,
    input  logic                 id_two_src_i,
    input  logic [REG_IDX_W-1:0] exe_dest_i,
    input  logic                 exe_wb_en_i,
    input  logic                 exe_mem_read_i,
    input  logic [REG_IDX_W-1:0] mem_dest_i,
    input  logic                 mem_wb_en_i,
    output logic                 hz_o
);

    logic exeHit;
    logic memHit;

    // Decide whether any live ID source collides with a result still in flight.
    always_comb begin
        exeHit = srcMatch(id_src1_i, id_use_src1_i, exe_dest_i)
               | srcMatch(id_src2_i, id_two_src_i,  exe_dest_i);
        memHit = srcMatch(id_src1_i, id_use_src1_i, mem_dest_i)
               | srcMatch(id_src2_i, id_two_src_i,  mem_dest_i);
        hz_o   = 1'b0;
        if (FWD_EN) begin
            hz_o = exeHit & exe_mem_read_i;
        end else begin
            hz_o = (exeHit & exe_wb_en_i) | (memHit & mem_wb_en_i);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Combines data hazards, data-memory waits and taken branches into freeze/flush
// controls, tracks memory waits with a timeout, and keeps saturating
// stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN      = 1'b0,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1_i,
    input  logic [REG_IDX_W-1:0] id_src2_i,
    input  logic                 id_use_src1_i,
    input  logic                 id_two_src_i,
    input  logic [REG_IDX_W-1:0] exe_dest_i,
    input  logic                 exe_wb_en_i,
    input  logic                 exe_mem_read_i,
    input  logic [REG_IDX_W-1:0] mem_dest_i,
    input  logic                 mem_wb_en_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    output logic                 freeze_pc_o,
    output logic                 freeze_if_reg_o,
    output logic                 flush_if_reg_o,
    output logic                 bubble_id_o,
    output logic                 freeze_back_o,
    output logic                 mem_err_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    hazard_state_e     state_q,       state_d;
    logic [WAIT_W-1:0] waitCnt_q,     waitCnt_d;
    logic              memErr_q,      memErr_d;
    logic              branchPend_q,  branchPend_d;
    logic [CNT_W-1:0]  stallCnt_q,    stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q,    flushCnt_d;

    logic         hz;
    logic         ms;
    logic         branchEff;
    logic         stallEvent;
    logic         flushEvent;
    hazard_ctrl_t ctrl;

    pipeline_hazard_ctrl_hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_src1_i      (id_src1_i),
        .id_src2_i      (id_src2_i),
        .id_use_src1_i  (id_use_src1_i),
        .id_two_src_i   (id_two_src_i),
        .exe_dest_i     (exe_dest_i),
        .exe_wb_en_i    (exe_wb_en_i),
        .exe_mem_read_i (exe_mem_read_i),
        .mem_dest_i     (mem_dest_i),
        .mem_wb_en_i    (mem_wb_en_i),
        .hz_o           (hz)
    );

    // Priority mux and next-state logic: ERROR beats a memory stall, which beats
    // a taken branch, which beats a data hazard. A branch seen while EX is frozen
    // (or in the release cycle) is remembered and flushed on the following RUN cycle.
    always_comb begin
        ms           = mem_req_i & ~mem_ready_i;
        branchEff    = branch_taken_i | branchPend_q;
        ctrl         = CTRL_IDLE;
        stallEvent   = 1'b0;
        flushEvent   = 1'b0;
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        memErr_d     = memErr_q;
        branchPend_d = branchPend_q;

        case (state_q)
            ERROR: begin
                ctrl.freezePc    = 1'b1;
                ctrl.freezeIfReg = 1'b1;
                ctrl.freezeBack  = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (ms) begin
                    ctrl.freezePc    = 1'b1;
                    ctrl.freezeIfReg = 1'b1;
                    ctrl.freezeBack  = 1'b1;
                    stallEvent       = 1'b1;
                    branchPend_d     = branchEff;
                    if (state_q == RUN) begin
                        state_d   = MEM_WAIT;
                        waitCnt_d = WAIT_W'(1);
                    end else if (waitCnt_q == WAIT_LIMIT) begin
                        state_d  = ERROR;
                        memErr_d = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + WAIT_W'(1);
                    end
                end else if (state_q == MEM_WAIT) begin
                    state_d      = RUN;
                    waitCnt_d    = '0;
                    branchPend_d = branchEff;
                end else if (branchEff) begin
                    ctrl.flushIfReg = 1'b1;
                    ctrl.bubbleId   = 1'b1;
                    flushEvent      = 1'b1;
                    branchPend_d    = 1'b0;
                end else if (hz) begin
                    ctrl.freezePc    = 1'b1;
                    ctrl.freezeIfReg = 1'b1;
                    ctrl.bubbleId    = 1'b1;
                    stallEvent       = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        stallCnt_d = stallCnt_q;
        if (stallEvent && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        flushCnt_d = flushCnt_q;
        if (flushEvent && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end

        if (rst) begin
            ctrl = CTRL_IDLE;
        end
    end

    // Sequencer state register: memory-wait tracking, sticky error and held branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            memErr_q     <= 1'b0;
            branchPend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            memErr_q     <= memErr_d;
            branchPend_q <= branchPend_d;
        end
    end

    // Saturating performance counters for stall cycles and acted-on branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign freeze_pc_o     = ctrl.freezePc;
    assign freeze_if_reg_o = ctrl.freezeIfReg;
    assign flush_if_reg_o  = ctrl.flushIfReg;
    assign bubble_id_o     = ctrl.bubbleId;
    assign freeze_back_o   = ctrl.freezeBack;
    assign mem_err_o       = memErr_q;
    assign stall_cnt_o     = stallCnt_q;
    assign flush_cnt_o     = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dutA has no forwarding, a short timeout and narrow counters; dutB has
// forwarding and the default timeout and counter width.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] idSrc1, idSrc2, exeDest, memDest;
    logic       idUseSrc1, idTwoSrc, exeWbEn, exeMemRead, memWbEn;
    logic       branchTaken, memReq, memReady;

    logic        fpcA, fifA, flifA, bubA, fbA, memErrA;
    logic [3:0]  stallCntA, flushCntA;
    logic        fpcB, fifB, flifB, bubB, fbB, memErrB;
    logic [15:0] stallCntB, flushCntB;

    logic [4:0] ctrlA, ctrlB;
    int checks = 0;
    int errors = 0;

    // Control bundle in the order {freeze_pc, freeze_if_reg, flush_if_reg, bubble_id, freeze_back}.
    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_HAZARD = 5'b11010;
    localparam logic [4:0] C_FLUSH  = 5'b00110;
    localparam logic [4:0] C_FREEZE = 5'b11001;

    assign ctrlA = {fpcA, fifA, flifA, bubA, fbA};
    assign ctrlB = {fpcB, fifB, flifB, bubB, fbB};

    // Free-running core clock.
    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst),
        .id_src1_i(idSrc1), .id_src2_i(idSrc2), .id_use_src1_i(idUseSrc1), .id_two_src_i(idTwoSrc),
        .exe_dest_i(exeDest), .exe_wb_en_i(exeWbEn), .exe_mem_read_i(exeMemRead),
        .mem_dest_i(memDest), .mem_wb_en_i(memWbEn), .branch_taken_i(branchTaken),
        .mem_req_i(memReq), .mem_ready_i(memReady),
        .freeze_pc_o(fpcA), .freeze_if_reg_o(fifA), .flush_if_reg_o(flifA), .bubble_id_o(bubA),
        .freeze_back_o(fbA), .mem_err_o(memErrA), .stall_cnt_o(stallCntA), .flush_cnt_o(flushCntA)
    );

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst),
        .id_src1_i(idSrc1), .id_src2_i(idSrc2), .id_use_src1_i(idUseSrc1), .id_two_src_i(idTwoSrc),
        .exe_dest_i(exeDest), .exe_wb_en_i(exeWbEn), .exe_mem_read_i(exeMemRead),
        .mem_dest_i(memDest), .mem_wb_en_i(memWbEn), .branch_taken_i(branchTaken),
        .mem_req_i(memReq), .mem_ready_i(memReady),
        .freeze_pc_o(fpcB), .freeze_if_reg_o(fifB), .flush_if_reg_o(flifB), .bubble_id_o(bubB),
        .freeze_back_o(fbB), .mem_err_o(memErrB), .stall_cnt_o(stallCntB), .flush_cnt_o(flushCntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic [3:0] src1, input logic use1, input logic [3:0] src2, input logic two,
        input logic [3:0] eDest, input logic eWb, input logic eLoad,
        input logic [3:0] mDest, input logic mWb,
        input logic br, input logic req, input logic rdy
    );
        idSrc1 = src1;  idUseSrc1 = use1;  idSrc2 = src2;  idTwoSrc = two;
        exeDest = eDest; exeWbEn = eWb;    exeMemRead = eLoad;
        memDest = mDest; memWbEn = mWb;
        branchTaken = br; memReq = req;    memReady = rdy;
        #1;
    endtask

    task automatic clearInputs();
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        rst = 1'b1;
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_ctrl_A", 32'(ctrlA), 32'(C_NONE));
        checkOutput("rst_ctrl_B", 32'(ctrlB), 32'(C_NONE));
        tick();
        rst = 1'b0;
        clearInputs();
        checkOutput("rst_stall_A", 32'(stallCntA), 32'd0);
        checkOutput("rst_flush_A", 32'(flushCntA), 32'd0);
        checkOutput("rst_memerr_A", 32'(memErrA), 32'd0);
        checkOutput("rst_stall_B", 32'(stallCntB), 32'd0);

        // EX writes R3 (not a load): stalls only without forwarding.
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("exe_hz_A", 32'(ctrlA), 32'(C_HAZARD));
        checkOutput("exe_nohz_B", 32'(ctrlB), 32'(C_NONE));
        tick();
        clearInputs();
        checkOutput("exe_hz_stall_A", 32'(stallCntA), 32'd1);
        checkOutput("exe_hz_stall_B", 32'(stallCntB), 32'd0);

        // Load-use: one bubble with forwarding, then the load is in MEM.
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_use_A", 32'(ctrlA), 32'(C_HAZARD));
        checkOutput("ld_use_B", 32'(ctrlB), 32'(C_HAZARD));
        tick();
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_mem_A", 32'(ctrlA), 32'(C_HAZARD));
        checkOutput("ld_mem_B", 32'(ctrlB), 32'(C_NONE));
        tick();
        clearInputs();
        checkOutput("ld_stall_A", 32'(stallCntA), 32'd3);
        checkOutput("ld_stall_B", 32'(stallCntB), 32'd1);

        // R15 on a source that is not read, then on a live src2.
        applyStimulus(4'd15, 1'b0, 4'd15, 1'b0, 4'd15, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("r15_dead_A", 32'(ctrlA), 32'(C_NONE));
        checkOutput("r15_dead_B", 32'(ctrlB), 32'(C_NONE));
        applyStimulus(4'd0, 1'b0, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("r15_src2_A", 32'(ctrlA), 32'(C_HAZARD));
        checkOutput("r15_src2_B", 32'(ctrlB), 32'(C_NONE));
        tick();

        // Taken branch with a simultaneous hazard: flush wins, no freeze.
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("br_hz_A", 32'(ctrlA), 32'(C_FLUSH));
        checkOutput("br_hz_B", 32'(ctrlB), 32'(C_FLUSH));
        tick();
        clearInputs();
        checkOutput("br_flush_A", 32'(flushCntA), 32'd1);
        checkOutput("br_stall_A", 32'(stallCntA), 32'd4);
        checkOutput("br_flush_B", 32'(flushCntB), 32'd1);
        checkOutput("br_stall_B", 32'(stallCntB), 32'd1);

        // Memory access ready on the 5th cycle, branch raised during the wait.
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mw_c0_A", 32'(ctrlA), 32'(C_FREEZE));
        tick();
        branchTaken = 1'b1;
        #1;
        checkOutput("mw_c1_A", 32'(ctrlA), 32'(C_FREEZE));
        checkOutput("mw_c1_B", 32'(ctrlB), 32'(C_FREEZE));
        tick();
        tick();
        checkOutput("mw_c3_B", 32'(ctrlB), 32'(C_FREEZE));
        tick();
        memReady = 1'b1;
        #1;
        checkOutput("mw_release_A", 32'(ctrlA), 32'(C_NONE));
        checkOutput("mw_release_B", 32'(ctrlB), 32'(C_NONE));
        tick();
        clearInputs();
        checkOutput("mw_brpend_A", 32'(ctrlA), 32'(C_FLUSH));
        checkOutput("mw_brpend_B", 32'(ctrlB), 32'(C_FLUSH));
        tick();
        checkOutput("mw_after_A", 32'(ctrlA), 32'(C_NONE));
        checkOutput("mw_stall_A", 32'(stallCntA), 32'd8);
        checkOutput("mw_flush_A", 32'(flushCntA), 32'd2);
        checkOutput("mw_stall_B", 32'(stallCntB), 32'd5);
        checkOutput("mw_flush_B", 32'(flushCntB), 32'd2);

        // Timeout on dutA: 9 stalled cycles (1 in RUN + 8 in MEM_WAIT) then ERROR.
        applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("to_pre_memerr_A", 32'(memErrA), 32'd0);
        checkOutput("to_pre_ctrl_A", 32'(ctrlA), 32'(C_FREEZE));
        tick();
        checkOutput("to_memerr_A", 32'(memErrA), 32'd1);
        checkOutput("to_stall_sat_A", 32'(stallCntA), 32'd15);
        checkOutput("to_stall_B", 32'(stallCntB), 32'd14);
        checkOutput("to_memerr_B", 32'(memErrB), 32'd0);
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("err_ctrl_A", 32'(ctrlA), 32'(C_FREEZE));
        tick();
        checkOutput("err_sticky_A", 32'(memErrA), 32'd1);
        checkOutput("err_noflush_A", 32'(flushCntA), 32'd2);

        // Reset out of ERROR.
        rst = 1'b1;
        clearInputs();
        checkOutput("err_rst_ctrl_A", 32'(ctrlA), 32'(C_NONE));
        tick();
        rst = 1'b0;
        clearInputs();
        checkOutput("post_rst_ctrl_A", 32'(ctrlA), 32'(C_NONE));
        checkOutput("post_rst_memerr_A", 32'(memErrA), 32'd0);
        checkOutput("post_rst_stall_A", 32'(stallCntA), 32'd0);
        checkOutput("post_rst_flush_A", 32'(flushCntA), 32'd0);

        // 20 consecutive load-use stalls: 4-bit counter saturates, 16-bit does not.
        applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        clearInputs();
        checkOutput("sat_stall_A", 32'(stallCntA), 32'd15);
        checkOutput("sat_stall_B", 32'(stallCntB), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
